wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Merges the result streams of the ALU, LSU, MUL and DIV pipes into the single register-file write-back port (wb_ix_inf) consumed by instruction issue.
- ALU/LSU/MUL have fixed latencies and are pre-scheduled by issue, so at most one of them is valid per cycle.
- DIV has variable latency and is absorbed through a one-entry holding slot. It commits in free write-back cycles.
- If DIV starves, the block asks issue to insert a bubble. It also pulses div_ix_done on DIV commit.

Parameters:
- REG_WIDTH, 5, GPR index width.
- DATA_WIDTH, 32, result width.
- STARVE_LIMIT, 4, cycles a held DIV result may wait before wb_div_starve asserts (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- alu_valid  in  1  ALU result valid.
- alu_rd  in  REG_WIDTH  ALU destination.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  LSU result valid.
- lsu_rd  in  REG_WIDTH  LSU destination.
- lsu_data  in  DATA_WIDTH  LSU result.
- mul_valid  in  1  MUL result valid.
- mul_rd  in  REG_WIDTH  MUL destination.
- mul_data  in  DATA_WIDTH  MUL result.
- div_valid  in  1  DIV result valid; held until accepted.
- div_ready  out  1  slot can accept a DIV result this cycle.
- div_rd  in  REG_WIDTH  DIV destination.
- div_data  in  DATA_WIDTH  DIV result.
- div_kill  in  1  discard the held and the incoming DIV result (younger than a taken branch).
- wb_ix_inf  out  wb_ix_inf_t  {wr_en, rd, wr_data} to issue/register file.
- div_ix_done  out  1  one-cycle pulse, DIV result committed or killed.
- wb_div_starve  out  1  issue must not fire while high.
- wb_collision_err  out  1  sticky: two fixed-latency sources valid in the same cycle.

Behaviour:
- All outputs registered, 1-cycle latency from source valid to wb_ix_inf.wr_en.
- Reset values: wb_ix_inf = '0, div_ix_done = 0, wb_div_starve = 0, wb_collision_err = 0, slot state EMPTY, starve counter 0.
- Fixed-source select: mul > lsu > alu priority (only one is legal).
  - Any two or more fixed valids in the same cycle set wb_collision_err until reset.
  - The highest-priority source still writes.
- fixed_busy = alu_valid | lsu_valid | mul_valid.
- rd == 0: wr_en forced 0 next cycle. The source still counts as busy, and a DIV to x0 still produces div_ix_done.
- Slot FSM:
  - EMPTY:
    - div_valid & ~div_kill & ~fixed_busy: bypass, written next cycle, div_ix_done next cycle; stay EMPTY.
    - div_valid & ~div_kill & fixed_busy: capture rd/data -> HELD, counter = 0.
    - div_valid & div_kill: drop, div_ix_done next cycle.
  - HELD:
    - div_kill: clear -> EMPTY, div_ix_done next cycle, counter = 0, no write.
    - ~fixed_busy: commit held entry, div_ix_done next cycle -> EMPTY.
    - else: counter saturating increment.
- div_ready = (state == EMPTY) | (HELD & ~fixed_busy & ~div_kill).
  - A new DIV accepted in the same cycle the held entry commits goes to HELD, since the port is used.
  - This is impossible while issue tracks one pending DIV; it must still be handled correctly.
- wb_div_starve registered: 1 when HELD and counter >= STARVE_LIMIT-1; cleared the cycle after leaving HELD.
- Reset asserted mid-operation: held entry discarded silently, no div_ix_done.

Decomposition:
- defines package:
  - wb_ix_inf_t is already shared.
  - Add typedef wb_src_e {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_LSU, WB_SRC_MUL, WB_SRC_DIV}, used as an internal select plus a debug signal.
  - Add localparam WB_STARVE_LIMIT.
- Sub-module wb_div_slot: EMPTY/HELD FSM, holding register, starve counter, div_ready/done/starve generation.
- The top level does fixed-source muxing, collision detect and output registers.

Test Plan:
- alu_valid=1, rd=5, data=0x1234 -> next cycle wr_en=1, rd=5, wr_data=0x1234; no error.
- div_valid=1, rd=7, data=0xCAFE, no fixed valid -> next cycle write rd=7 and div_ix_done=1; div_ready stays 1.
- mul_valid held 3 cycles while div_valid rd=9 arrives (STARVE_LIMIT=2):
  - DIV captured, wb_div_starve=1 while blocked.
  - First free cycle writes rd=9 with div_ix_done; starve clears next cycle.
- HELD entry, then div_kill=1 -> no write of the DIV rd, div_ix_done pulse, div_ready=1 next cycle.
- alu_valid & lsu_valid same cycle -> LSU value written, wb_collision_err=1 sticky until rst=0.
- alu_valid rd=0, data=0xFFFF -> wr_en stays 0. rst pulled low while HELD -> all outputs 0 immediately, no div_ix_done.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: result bus struct, source select enum, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_arbiter_pkg;

  localparam int WB_REG_WIDTH    = 5;
  localparam int WB_DATA_WIDTH   = 32;
  localparam int WB_STARVE_LIMIT = 4;

  // Register-file write port seen by issue.
  typedef struct packed {
    logic                     wr_en;
    logic [WB_REG_WIDTH-1:0]  rd;
    logic [WB_DATA_WIDTH-1:0] wr_data;
  } wb_ix_inf_t;

  // Which pipe owns the write-back port in a given cycle.
  typedef enum logic [2:0] {
    WB_SRC_NONE = 3'd0,
    WB_SRC_ALU  = 3'd1,
    WB_SRC_LSU  = 3'd2,
    WB_SRC_MUL  = 3'd3,
    WB_SRC_DIV  = 3'd4
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of all pipe result streams plus the merged write-back outputs.
// Latency: n/a (wiring only).
// Backpressure: only the DIV stream is back-pressured, through div_ready.
interface wb_arbiter_if #(
  parameter int REG_WIDTH  = wb_arbiter_pkg::WB_REG_WIDTH,
  parameter int DATA_WIDTH = wb_arbiter_pkg::WB_DATA_WIDTH
);
  import wb_arbiter_pkg::*;

  logic                  alu_valid;
  logic [REG_WIDTH-1:0]  alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  lsu_valid;
  logic [REG_WIDTH-1:0]  lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  mul_valid;
  logic [REG_WIDTH-1:0]  mul_rd;
  logic [DATA_WIDTH-1:0] mul_data;
  logic                  div_valid;
  logic                  div_ready;
  logic [REG_WIDTH-1:0]  div_rd;
  logic [DATA_WIDTH-1:0] div_data;
  logic                  div_kill;
  wb_ix_inf_t            wb_ix_inf;
  logic                  div_ix_done;
  logic                  wb_div_starve;
  logic                  wb_collision_err;
  wb_src_e               wb_src_dbg;

  // Pipes and issue side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mul_valid, mul_rd, mul_data,
    output div_valid, div_rd, div_data, div_kill,
    input  div_ready, wb_ix_inf, div_ix_done, wb_div_starve, wb_collision_err, wb_src_dbg
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mul_valid, mul_rd, mul_data,
    input  div_valid, div_rd, div_data, div_kill,
    output div_ready, wb_ix_inf, div_ix_done, wb_div_starve, wb_collision_err, wb_src_dbg
  );

endinterface

// File: rtl/wb_div_slot.sv
// One-entry DIV holding slot: bypass when the port is free, hold otherwise, starve/done flags.
// Latency: div_wr_o is combinational this cycle; done/starve are registered (1 cycle).
// Backpressure: div_ready_o low while an entry is held and the port is busy or being killed.
module wb_div_slot #(
  parameter int REG_WIDTH    = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_valid_i,
  input  logic [REG_WIDTH-1:0]  div_rd_i,
  input  logic [DATA_WIDTH-1:0] div_data_i,
  input  logic                  div_kill_i,
  input  logic                  fixed_busy_i,
  output logic                  div_ready_o,
  output logic                  div_wr_o,
  output logic [REG_WIDTH-1:0]  div_wr_rd_o,
  output logic [DATA_WIDTH-1:0] div_wr_data_o,
  output logic                  div_done_o,
  output logic                  div_starve_o
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HELD  = 1'b1;

  // Counter only needs to reach STARVE_LIMIT-1; it saturates there.
  localparam int            CW      = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

  logic                  state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [REG_WIDTH-1:0]  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  starve_q, starve_d;

  // A held entry frees its slot in the same cycle it commits, so a new DIV may be taken then.
  assign div_ready_o = (state_q == ST_EMPTY) | (~fixed_busy_i & ~div_kill_i);

  // Starve looks at the current hold age, so it drops one cycle after the slot empties.
  assign starve_d = (state_q == ST_HELD) && (cnt_q >= CNT_MAX);

  // Slot next-state: bypass, capture, commit, kill and age tracking.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    data_d        = data_q;
    done_d        = 1'b0;
    div_wr_o      = 1'b0;
    div_wr_rd_o   = div_rd_i;
    div_wr_data_o = div_data_i;
    if (state_q == ST_EMPTY) begin
      if (div_valid_i) begin
        if (div_kill_i) begin
          done_d = 1'b1;
        end else if (!fixed_busy_i) begin
          div_wr_o = 1'b1;
          done_d   = 1'b1;
        end else begin
          state_d = ST_HELD;
          cnt_d   = '0;
          rd_d    = div_rd_i;
          data_d  = div_data_i;
        end
      end
    end else begin
      if (div_kill_i) begin
        state_d = ST_EMPTY;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else if (!fixed_busy_i) begin
        div_wr_o      = 1'b1;
        div_wr_rd_o   = rd_q;
        div_wr_data_o = data_q;
        done_d        = 1'b1;
        state_d       = ST_EMPTY;
        // Port is taken by the held entry, so a simultaneous new DIV must wait in the slot.
        if (div_valid_i) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          rd_d    = div_rd_i;
          data_d  = div_data_i;
        end
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Slot registers; reset drops any held entry without signalling done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      done_q   <= done_d;
      starve_q <= starve_d;
    end
  end

  assign div_done_o   = done_q;
  assign div_starve_o = starve_q;

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU/LSU/MUL/DIV results onto the single register-file write-back port.
// Latency: 1 cycle from source valid to wb_ix_inf.wr_en; all outputs except div_ready registered.
// Backpressure: fixed pipes never stall; DIV waits in a one-entry slot and raises starve.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int REG_WIDTH    = WB_REG_WIDTH,
  parameter int DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  wb_arbiter_if.slave bus
);

  logic                  fixed_busy;
  logic                  collision;
  logic                  div_wr;
  logic [REG_WIDTH-1:0]  div_wr_rd;
  logic [DATA_WIDTH-1:0] div_wr_data;
  wb_src_e               sel_src;
  logic [REG_WIDTH-1:0]  sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  wb_ix_inf_t            wb_d, wb_q;
  logic                  err_q;
  wb_src_e               src_q;

  assign fixed_busy = bus.alu_valid | bus.lsu_valid | bus.mul_valid;
  assign collision  = (bus.alu_valid & bus.lsu_valid) |
                      (bus.alu_valid & bus.mul_valid) |
                      (bus.lsu_valid & bus.mul_valid);

  wb_div_slot #(
    .REG_WIDTH    (REG_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_div_slot (
    .clk           (clk),
    .rst           (rst),
    .div_valid_i   (bus.div_valid),
    .div_rd_i      (bus.div_rd),
    .div_data_i    (bus.div_data),
    .div_kill_i    (bus.div_kill),
    .fixed_busy_i  (fixed_busy),
    .div_ready_o   (bus.div_ready),
    .div_wr_o      (div_wr),
    .div_wr_rd_o   (div_wr_rd),
    .div_wr_data_o (div_wr_data),
    .div_done_o    (bus.div_ix_done),
    .div_starve_o  (bus.wb_div_starve)
  );

  // Source select: MUL over LSU over ALU, DIV only when no fixed pipe is writing.
  always_comb begin
    sel_src  = WB_SRC_NONE;
    sel_rd   = div_wr_rd;
    sel_data = div_wr_data;
    if (bus.mul_valid) begin
      sel_src  = WB_SRC_MUL;
      sel_rd   = bus.mul_rd;
      sel_data = bus.mul_data;
    end else if (bus.lsu_valid) begin
      sel_src  = WB_SRC_LSU;
      sel_rd   = bus.lsu_rd;
      sel_data = bus.lsu_data;
    end else if (bus.alu_valid) begin
      sel_src  = WB_SRC_ALU;
      sel_rd   = bus.alu_rd;
      sel_data = bus.alu_data;
    end else if (div_wr) begin
      sel_src = WB_SRC_DIV;
    end
  end

  // Write-back payload; x0 is never written, and idle cycles present an all-zero bus.
  always_comb begin
    wb_d = '0;
    if ((sel_src != WB_SRC_NONE) && (sel_rd != '0)) begin
      wb_d.wr_en   = 1'b1;
      wb_d.rd      = sel_rd;
      wb_d.wr_data = sel_data;
    end
  end

  // Output registers; the collision flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q  <= '0;
      err_q <= 1'b0;
      src_q <= WB_SRC_NONE;
    end else begin
      wb_q  <= wb_d;
      err_q <= err_q | collision;
      src_q <= sel_src;
    end
  end

  assign bus.wb_ix_inf        = wb_q;
  assign bus.wb_collision_err = err_q;
  assign bus.wb_src_dbg       = src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Write-back arbiter bench: directed scenarios plus random traffic against a queue-based model.
// Latency: model predicts registered outputs one cycle after inputs.
// Backpressure: driver holds a DIV result until the model says it is accepted or killed.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int SL = 2;

  logic clk;
  logic rst;

  wb_arbiter_if #(.REG_WIDTH(5), .DATA_WIDTH(32)) bus ();

  wb_arbiter #(
    .REG_WIDTH    (5),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending DIV results as a queue with per-entry wait age.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          age;
  } dent_t;

  dent_t       dq[$];
  logic        exp_wr, exp_done, exp_starve, exp_err;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        acc_last;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    exp_wr = 0; exp_rd = 0; exp_data = 0;
    exp_done = 0; exp_starve = 0; exp_err = 0;
    acc_last = 0;
  endtask

  task automatic clr_in();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.mul_valid = 0; bus.mul_rd = 0; bus.mul_data = 0;
    bus.div_valid = 0; bus.div_rd = 0; bus.div_data = 0;
    bus.div_kill  = 0;
  endtask

  // One cycle of the specification's rules, applied to the currently driven inputs.
  task automatic model_step();
    int          n;
    logic        rdy;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    dent_t       e;
    n    = int'(bus.alu_valid) + int'(bus.lsu_valid) + int'(bus.mul_valid);
    rdy  = (dq.size() == 0) || (n == 0 && !bus.div_kill);
    chk("div_ready", bus.div_ready, rdy);
    acc_last   = bus.div_valid && rdy;
    exp_starve = (dq.size() != 0) && (dq[0].age >= SL - 1);
    exp_wr = 0; exp_rd = 0; exp_data = 0; exp_done = 0;
    if (n > 0) begin
      wrd  = bus.mul_valid ? bus.mul_rd   : bus.lsu_valid ? bus.lsu_rd   : bus.alu_rd;
      wdat = bus.mul_valid ? bus.mul_data : bus.lsu_valid ? bus.lsu_data : bus.alu_data;
      exp_wr = (wrd != 0); exp_rd = wrd; exp_data = wdat;
    end
    if (bus.div_kill) begin
      exp_done = (dq.size() != 0) || acc_last;
      dq.delete();
    end else begin
      foreach (dq[i]) dq[i].age++;
      if (acc_last) dq.push_back('{bus.div_rd, bus.div_data, 0});
      if (n == 0 && dq.size() != 0) begin
        e = dq.pop_front();
        exp_wr = (e.rd != 0); exp_rd = e.rd; exp_data = e.data;
        exp_done = 1;
      end
    end
    if (n >= 2) exp_err = 1;
  endtask

  task automatic cmp_out();
    chk("wr_en", bus.wb_ix_inf.wr_en, exp_wr);
    if (exp_wr) begin
      chk("rd", bus.wb_ix_inf.rd, exp_rd);
      chk("wr_data", bus.wb_ix_inf.wr_data, exp_data);
    end
    chk("div_ix_done", bus.div_ix_done, exp_done);
    chk("wb_div_starve", bus.wb_div_starve, exp_starve);
    chk("wb_collision_err", bus.wb_collision_err, exp_err);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge after comparing.
  task automatic tick();
    #1;
    model_step();
    @(negedge clk);
    cmp_out();
  endtask

  // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
  task automatic do_reset(input int cycles);
    rst = 0;
    clr_in();
    #1;
    model_reset();
    cmp_out();
    repeat (cycles) @(negedge clk);
    rst = 1;
  endtask

  initial begin
    logic        pend;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    int          r;

    rst = 0;
    clr_in();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_wr_en", bus.wb_ix_inf.wr_en, 0);
    chk("rst_done", bus.div_ix_done, 0);
    chk("rst_starve", bus.wb_div_starve, 0);
    chk("rst_err", bus.wb_collision_err, 0);
    chk("rst_ready", bus.div_ready, 1);

    // ALU write.
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h1234;
    tick();
    chk("alu_wr_en", bus.wb_ix_inf.wr_en, 1);
    chk("alu_rd", bus.wb_ix_inf.rd, 5);
    chk("alu_data", bus.wb_ix_inf.wr_data, 32'h1234);
    chk("alu_err", bus.wb_collision_err, 0);
    clr_in();

    // DIV bypass on a free port.
    bus.div_valid = 1; bus.div_rd = 7; bus.div_data = 32'hCAFE;
    tick();
    chk("byp_rd", bus.wb_ix_inf.rd, 7);
    chk("byp_data", bus.wb_ix_inf.wr_data, 32'hCAFE);
    chk("byp_done", bus.div_ix_done, 1);
    chk("byp_ready", bus.div_ready, 1);
    clr_in();

    // MUL for 3 cycles blocks a DIV to x9.
    bus.mul_valid = 1; bus.mul_rd = 3; bus.mul_data = 32'h333;
    bus.div_valid = 1; bus.div_rd = 9; bus.div_data = 32'h9999;
    tick();
    chk("blk_mul_rd", bus.wb_ix_inf.rd, 3);
    chk("blk_starve0", bus.wb_div_starve, 0);
    bus.div_valid = 0;
    tick();
    chk("blk_starve1", bus.wb_div_starve, 0);
    tick();
    chk("blk_starve2", bus.wb_div_starve, 1);
    bus.mul_valid = 0;
    tick();
    chk("blk_div_rd", bus.wb_ix_inf.rd, 9);
    chk("blk_div_done", bus.div_ix_done, 1);
    chk("blk_starve3", bus.wb_div_starve, 1);
    tick();
    chk("blk_starve_clr", bus.wb_div_starve, 0);
    chk("blk_done_clr", bus.div_ix_done, 0);

    // Kill a held entry.
    bus.mul_valid = 1; bus.mul_rd = 8; bus.mul_data = 32'h8;
    bus.div_valid = 1; bus.div_rd = 11; bus.div_data = 32'hB;
    tick();
    clr_in();
    bus.div_kill = 1;
    tick();
    chk("kill_wr_en", bus.wb_ix_inf.wr_en, 0);
    chk("kill_done", bus.div_ix_done, 1);
    bus.div_kill = 0;
    #1;
    chk("kill_ready", bus.div_ready, 1);

    // ALU and LSU collide; LSU wins, error sticks.
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h11;
    bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h22;
    tick();
    chk("col_rd", bus.wb_ix_inf.rd, 2);
    chk("col_data", bus.wb_ix_inf.wr_data, 32'h22);
    chk("col_err", bus.wb_collision_err, 1);
    clr_in();
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFF;
    tick();
    chk("x0_wr_en", bus.wb_ix_inf.wr_en, 0);
    chk("col_sticky", bus.wb_collision_err, 1);
    clr_in();

    // Reset while an entry is held and starving.
    bus.mul_valid = 1; bus.mul_rd = 4; bus.mul_data = 32'h44;
    bus.div_valid = 1; bus.div_rd = 13; bus.div_data = 32'hD;
    tick();
    bus.div_valid = 0;
    tick();
    tick();
    chk("pre_rst_starve", bus.wb_div_starve, 1);
    do_reset(2);
    chk("arst_err", bus.wb_collision_err, 0);
    tick();
    chk("post_rst_done", bus.div_ix_done, 0);
    chk("post_rst_wr_en", bus.wb_ix_inf.wr_en, 0);

    // Random traffic.
    pend = 0; p_rd = 0; p_data = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 3));
        pend = 0;
      end
      clr_in();
      r = $urandom_range(0, 99);
      if (r >= 97) begin
        bus.alu_valid = 1; bus.lsu_valid = $urandom_range(0, 1); bus.mul_valid = !bus.lsu_valid;
        if ($urandom_range(0, 1) == 1) bus.lsu_valid = 1;
      end else if (r >= 75) bus.mul_valid = 1;
      else if (r >= 55) bus.lsu_valid = 1;
      else if (r >= 35) bus.alu_valid = 1;
      bus.alu_rd = 5'($urandom); bus.alu_data = $urandom;
      bus.lsu_rd = 5'($urandom); bus.lsu_data = $urandom;
      bus.mul_rd = 5'($urandom); bus.mul_data = $urandom;
      if ($urandom_range(0, 9) == 0) bus.mul_rd = 0;
      if (!pend && $urandom_range(0, 9) < 4) begin
        pend   = 1;
        p_rd   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        p_data = $urandom;
      end
      bus.div_valid = pend;
      bus.div_rd    = p_rd;
      bus.div_data  = p_data;
      bus.div_kill  = ($urandom_range(0, 24) == 0);
      tick();
      if (acc_last || bus.div_kill) pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
